// File: rtl/output_pkg.sv
// -----------------------------------------------------------------------------
// output_pkg
// Shared types and defaults for the analog output path.
//   pwm_state_t          : states of the PWM generator (idle / running / draining)
//   PWM_WIDTH_DEFAULT    : default duty/sample width
//   PWM_PRESCALE_DEFAULT : default clock cycles per PWM tick
//   pwm_period_ticks()   : ticks in one PWM period for a given width
// -----------------------------------------------------------------------------
package output_pkg;

  typedef enum logic [1:0] {
    PWM_IDLE,
    PWM_RUN,
    PWM_DRAIN
  } pwm_state_t;

  localparam int PWM_WIDTH_DEFAULT    = 8;
  localparam int PWM_PRESCALE_DEFAULT = 4;

  // One code short of 2^width so that the all-ones duty code stays high for
  // the whole period.
  function automatic int pwm_period_ticks(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// -----------------------------------------------------------------------------
// pwm_prescaler
// Divides the system clock down to the PWM tick rate.
//   clk   : system clock
//   reset : synchronous active-low reset
//   clear : hold the prescale counter at zero
//   run   : advance the prescale counter
//   tick  : high in the last clock cycle of each tick (pre == PRESCALE-1)
// -----------------------------------------------------------------------------
module pwm_prescaler
  import output_pkg::*;
#(
  parameter int PRESCALE = PWM_PRESCALE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  // A one-bit counter is kept even for PRESCALE=1; it simply never leaves 0.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  always_comb begin
    pre_d = pre_q;
    if (clear) begin
      pre_d = '0;
    end else if (run) begin
      pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign tick = run && !clear && (pre_q == PRE_MAX);

endmodule

// File: rtl/pwm_gen.sv
// -----------------------------------------------------------------------------
// pwm_gen
// Turns a stream of duty codes into a PWM waveform. Samples land in a
// one-deep pending register and are only committed at period boundaries, so
// duty changes never produce a glitch. Dropping pwm_enable lets the current
// period finish before going idle.
//   clk          : system clock
//   reset        : synchronous active-low reset
//   pwm_enable   : level, 1 = produce PWM
//   sample_data  : duty code (all ones = 100 %)
//   sample_valid : sample_data valid
//   sample_ready : a sample can be accepted
//   pwm_out      : PWM waveform
//   period_start : one-cycle pulse in the first cycle of every period
//   active       : generator is not idle
// -----------------------------------------------------------------------------
module pwm_gen
  import output_pkg::*;
#(
  parameter int WIDTH    = PWM_WIDTH_DEFAULT,
  parameter int PRESCALE = PWM_PRESCALE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_enable,
  input  logic [WIDTH-1:0] sample_data,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             pwm_out,
  output logic             period_start,
  output logic             active
);

  // Last count value of a period: 2^WIDTH-2.
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(pwm_period_ticks(WIDTH) - 1);

  pwm_state_t       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_act_q, duty_act_d;
  logic [WIDTH-1:0] duty_pend_q, duty_pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             period_start_q, period_start_d;

  logic tick;
  logic boundary;
  logic commit;
  logic accept;
  logic pre_clear;

  assign pre_clear = (state_q == PWM_IDLE);

  pwm_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clear(pre_clear),
    .run  (!pre_clear),
    .tick (tick)
  );

  assign boundary     = tick && (cnt_q == CNT_MAX);
  assign sample_ready = reset && !pend_valid_q;
  assign accept       = sample_valid && sample_ready;

  // Next-state logic. A boundary with pwm_enable high always starts a new
  // period (commit + period_start), whether we were running or draining;
  // with pwm_enable low it ends in IDLE without touching the duty.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    duty_act_d     = duty_act_q;
    duty_pend_d    = duty_pend_q;
    pend_valid_d   = pend_valid_q;
    period_start_d = 1'b0;
    commit         = 1'b0;

    if (tick) begin
      cnt_d = boundary ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      PWM_IDLE: begin
        cnt_d = '0;
        if (pwm_enable) begin
          state_d        = PWM_RUN;
          commit         = 1'b1;
          period_start_d = 1'b1;
        end
      end
      PWM_RUN: begin
        if (boundary) begin
          if (pwm_enable) begin
            commit         = 1'b1;
            period_start_d = 1'b1;
          end else begin
            state_d = PWM_IDLE;
          end
        end else if (!pwm_enable) begin
          state_d = PWM_DRAIN;
        end
      end
      PWM_DRAIN: begin
        if (boundary) begin
          if (pwm_enable) begin
            state_d        = PWM_RUN;
            commit         = 1'b1;
            period_start_d = 1'b1;
          end else begin
            state_d = PWM_IDLE;
          end
        end else if (pwm_enable) begin
          state_d = PWM_RUN;
        end
      end
      default: state_d = PWM_IDLE;
    endcase

    // Commit and accept are mutually exclusive on pend_valid_q, so a sample
    // taken on a boundary edge waits for the following boundary.
    if (commit && pend_valid_q) begin
      duty_act_d   = duty_pend_q;
      pend_valid_d = 1'b0;
    end
    if (accept) begin
      duty_pend_d  = sample_data;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= PWM_IDLE;
      cnt_q          <= '0;
      duty_act_q     <= '0;
      duty_pend_q    <= '0;
      pend_valid_q   <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      duty_act_q     <= duty_act_d;
      duty_pend_q    <= duty_pend_d;
      pend_valid_q   <= pend_valid_d;
      period_start_q <= period_start_d;
    end
  end

  assign active       = (state_q != PWM_IDLE);
  assign pwm_out      = active && (cnt_q < duty_act_q);
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_pwm_gen
// Directed bench for pwm_gen with WIDTH=8, PRESCALE=4 (1020-cycle period).
// -----------------------------------------------------------------------------
module tb_pwm_gen;

  localparam int WIDTH    = 8;
  localparam int PRESCALE = 4;
  localparam int PERIOD   = PRESCALE * ((1 << WIDTH) - 1);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             pwm_enable = 1'b0;
  logic [WIDTH-1:0] sample_data = '0;
  logic             sample_valid = 1'b0;
  logic             sample_ready;
  logic             pwm_out;
  logic             period_start;
  logic             active;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [WIDTH-1:0] duty;
    int               exp_high;
    string            name;
  } vec_t;

  vec_t vecs[6];

  pwm_gen #(
    .WIDTH   (WIDTH),
    .PRESCALE(PRESCALE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pwm_enable  (pwm_enable),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .pwm_out     (pwm_out),
    .period_start(period_start),
    .active      (active)
  );

  always #5 clk = ~clk;

  // Hard stop in case something never terminates.
  initial begin
    repeat (200000) @(posedge clk);
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    pwm_enable   = 1'b0;
    sample_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic send_sample(input logic [WIDTH-1:0] d, input string name);
    bit done = 0;
    sample_data  = d;
    sample_valid = 1'b1;
    for (int i = 0; i < 3 * PERIOD && !done; i++) begin
      if (sample_ready) done = 1;
      step();
    end
    sample_valid = 1'b0;
    checkOutput({name, " sample accepted"}, int'(done), 1);
  endtask

  // Walks the current period from cycle start_idx to its end, comparing
  // pwm_out against "high for the first exp_high cycles", then checks that the
  // next period begins. A held sample_valid is dropped once accepted.
  task automatic measure_period(input int exp_high, input int start_idx,
                                input string name, output int accept_idx);
    int highs = 0;
    int bad = 0;
    int stray_ps = 0;
    int inactive = 0;
    int exp_highs;
    accept_idx = -1;
    for (int i = start_idx; i < PERIOD; i++) begin
      if (pwm_out) highs++;
      if (pwm_out != (i < exp_high)) bad++;
      if (i > 0 && period_start) stray_ps++;
      if (!active) inactive++;
      if (sample_valid && sample_ready && accept_idx < 0) accept_idx = i;
      step();
      if (accept_idx == i) sample_valid = 1'b0;
    end
    exp_highs = ((exp_high < PERIOD) ? exp_high : PERIOD) - start_idx;
    if (exp_highs < 0) exp_highs = 0;
    checkOutput({name, " high cycles"}, highs, exp_highs);
    checkOutput({name, " misplaced pwm cycles"}, bad, 0);
    checkOutput({name, " stray period_start"}, stray_ps, 0);
    checkOutput({name, " inactive cycles"}, inactive, 0);
    checkOutput({name, " next period_start"}, int'(period_start), 1);
  endtask

  // One table entry: load the duty while idle, enable, and check two periods.
  task automatic applyStimulus(input vec_t v);
    int acc;
    do_reset();
    step();
    send_sample(v.duty, v.name);
    checkOutput({v.name, " idle active"}, int'(active), 0);
    checkOutput({v.name, " idle pwm_out"}, int'(pwm_out), 0);
    pwm_enable = 1'b1;
    step();
    checkOutput({v.name, " enable period_start"}, int'(period_start), 1);
    checkOutput({v.name, " enable active"}, int'(active), 1);
    measure_period(v.exp_high, 0, {v.name, " p1"}, acc);
    measure_period(v.exp_high, 0, {v.name, " p2"}, acc);
    pwm_enable = 1'b0;
  endtask

  // Runs one period toggling pwm_enable at given cycles, then checks state.
  task automatic run_disable(input int drop_at, input int raise_at, input int exp_high,
                             input string name, input int exp_ps, input int exp_active);
    int bad = 0;
    int inactive = 0;
    int stray_ps = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (pwm_out != (i < exp_high)) bad++;
      if (!active) inactive++;
      if (i > 0 && period_start) stray_ps++;
      if (i == drop_at) pwm_enable = 1'b0;
      if (i == raise_at) pwm_enable = 1'b1;
      step();
    end
    checkOutput({name, " misplaced pwm cycles"}, bad, 0);
    checkOutput({name, " inactive cycles"}, inactive, 0);
    checkOutput({name, " stray period_start"}, stray_ps, 0);
    checkOutput({name, " end period_start"}, int'(period_start), exp_ps);
    checkOutput({name, " end active"}, int'(active), exp_active);
    checkOutput({name, " end pwm_out"}, int'(pwm_out), exp_active);
  endtask

  initial begin
    int acc;
    int bad;

    vecs[0] = '{duty: 8'd0,   exp_high: 0,    name: "duty0"};
    vecs[1] = '{duty: 8'd1,   exp_high: 4,    name: "duty1"};
    vecs[2] = '{duty: 8'd64,  exp_high: 256,  name: "duty64"};
    vecs[3] = '{duty: 8'd128, exp_high: 512,  name: "duty128"};
    vecs[4] = '{duty: 8'd254, exp_high: 1016, name: "duty254"};
    vecs[5] = '{duty: 8'd255, exp_high: 1020, name: "duty255"};

    // Reset and idle behaviour.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("reset sample_ready", int'(sample_ready), 0);
      checkOutput("reset pwm_out", int'(pwm_out), 0);
      checkOutput("reset period_start", int'(period_start), 0);
      checkOutput("reset active", int'(active), 0);
    end
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (pwm_out || period_start || active || !sample_ready) bad++;
    end
    checkOutput("idle outputs", bad, 0);
    checkOutput("idle sample_ready", int'(sample_ready), 1);

    // Table of duty values.
    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Update with back-pressure: 128 accepted mid-period, 200 held until commit.
    do_reset();
    step();
    send_sample(8'd64, "bp duty64");
    pwm_enable = 1'b1;
    step();
    checkOutput("bp first period_start", int'(period_start), 1);
    checkOutput("bp ready at start", int'(sample_ready), 1);
    sample_data  = 8'd128;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    checkOutput("bp 128 accepted", int'(sample_ready), 0);
    sample_data  = 8'd200;
    sample_valid = 1'b1;
    measure_period(256, 1, "bp p1", acc);
    checkOutput("bp 200 held in p1", acc, -1);
    measure_period(512, 0, "bp p2", acc);
    checkOutput("bp 200 accept cycle", acc, 0);
    checkOutput("bp valid dropped", int'(sample_valid), 0);
    measure_period(800, 0, "bp p3", acc);

    // Disable mid-period: drain to the boundary and go idle.
    do_reset();
    step();
    send_sample(8'd128, "drain duty128");
    pwm_enable = 1'b1;
    step();
    checkOutput("drain period_start", int'(period_start), 1);
    run_disable(300, -1, 512, "drain", 0, 0);
    step();
    checkOutput("drain stays idle", int'(active), 0);

    // Disable then re-enable: period continues and restarts normally.
    do_reset();
    step();
    send_sample(8'd128, "reen duty128");
    pwm_enable = 1'b1;
    step();
    run_disable(300, 600, 512, "reen", 1, 1);
    measure_period(512, 0, "reen p2", acc);

    // Reset mid-period with a pending sample.
    do_reset();
    step();
    send_sample(8'd255, "rst duty255");
    pwm_enable = 1'b1;
    step();
    sample_data  = 8'd50;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    checkOutput("rst pending held", int'(sample_ready), 0);
    bad = 0;
    for (int i = 1; i < 100; i++) begin
      if (!pwm_out) bad++;
      step();
    end
    checkOutput("rst pre-reset pwm high", bad, 0);
    reset      = 1'b0;
    pwm_enable = 1'b0;
    step();
    checkOutput("rst pwm_out", int'(pwm_out), 0);
    checkOutput("rst active", int'(active), 0);
    checkOutput("rst period_start", int'(period_start), 0);
    checkOutput("rst sample_ready low", int'(sample_ready), 0);
    reset = 1'b1;
    step();
    checkOutput("rst pending dropped", int'(sample_ready), 1);
    pwm_enable = 1'b1;
    step();
    checkOutput("rst reenable period_start", int'(period_start), 1);
    checkOutput("rst reenable pwm_out", int'(pwm_out), 0);
    measure_period(0, 0, "rst duty0", acc);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
